// File: rtl/vector_feeder.sv
// vector_feeder: CSR-started DMA that streams memory words into an accelerator and captures its result.
// Optional interrupt output and CSR 2 bit2 status are built only when FEEDER_IRQ_EN is defined.
module vector_feeder #(
    parameter int ACC_DRAIN  = 7,
    parameter int ACC_RD_LAT = 6
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [1:0]  csr_address_i,
    input  logic        csr_write_i,
    input  logic        csr_read_i,
    input  logic [31:0] csr_writedata_i,
    output logic [31:0] csr_readdata_o,
    output logic [31:0] mem_address_o,
    output logic        mem_read_o,
    input  logic        mem_waitrequest_i,
    input  logic [31:0] mem_readdata_i,
    input  logic        mem_readdatavalid_i,
    output logic        acc_address_o,
    output logic        acc_write_o,
    output logic        acc_read_o,
    output logic [31:0] acc_writedata_o,
    input  logic [31:0] acc_readdata_i
`ifdef FEEDER_IRQ_EN
    ,
    output logic        irq_o
`endif
);
    typedef enum logic [3:0] {IDLE, CLEAR, FETCH, WAIT_DATA, PUSH, DRAIN, RD_REQ, RD_WAIT, DONE} state_t;
    localparam logic [31:0] DRAIN_LAST = 32'(ACC_DRAIN - 1);
    localparam logic [31:0] RD_LAST    = 32'(ACC_RD_LAT);
    state_t      state_q, state_d;
    logic [31:0] base_q, base_d, len_q, len_d, idx_q, idx_d;
    logic [31:0] result_q, result_d, data_q, data_d, cnt_q, cnt_d;
    logic        done_q, done_d;
    logic        busy, ctrl_wr, start;
    logic [31:0] status;
    assign busy    = state_q != IDLE;
    assign ctrl_wr = csr_write_i && csr_address_i == 2'd2;
    assign start   = ctrl_wr && csr_writedata_i[0] && !busy;
`ifdef FEEDER_IRQ_EN
    logic irq_q, irq_d;
    assign irq_o  = irq_q;
    assign status = {29'b0, irq_q, done_q, busy};
    assign irq_d  = state_q == DONE || (irq_q && !(ctrl_wr && csr_writedata_i[1]));
`else
    assign status = {30'b0, done_q, busy};
`endif
    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        len_d    = len_q;
        idx_d    = idx_q;
        result_d = result_q;
        data_d   = data_q;
        cnt_d    = cnt_q;
        done_d   = done_q;
        if (!busy && csr_write_i && csr_address_i == 2'd0) base_d = csr_writedata_i;
        if (!busy && csr_write_i && csr_address_i == 2'd1) len_d = csr_writedata_i;
        if (start) done_d = 1'b0;
`ifdef FEEDER_IRQ_EN
        if (ctrl_wr && csr_writedata_i[1]) done_d = 1'b0;
`endif
        case (state_q)
            IDLE:      state_d = start ? CLEAR : IDLE;
            CLEAR: begin
                idx_d    = '0;
                state_d  = len_q != 0 ? FETCH : DONE;
                result_d = len_q != 0 ? result_q : '0;
            end
            FETCH:     state_d = mem_waitrequest_i ? FETCH : WAIT_DATA;
            WAIT_DATA: begin
                data_d  = mem_readdatavalid_i ? mem_readdata_i : data_q;
                state_d = mem_readdatavalid_i ? PUSH : WAIT_DATA;
            end
            PUSH: begin
                idx_d   = idx_q + 32'd1;
                cnt_d   = '0;
                state_d = idx_q + 32'd1 < len_q ? FETCH : DRAIN;
            end
            DRAIN: begin
                cnt_d   = cnt_q + 32'd1;
                state_d = cnt_q == DRAIN_LAST ? RD_REQ : DRAIN;
            end
            // cnt_q equals the number of cycles elapsed since the RD_REQ cycle
            RD_REQ: begin
                cnt_d   = 32'd1;
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                cnt_d    = cnt_q + 32'd1;
                result_d = cnt_q == RD_LAST ? acc_readdata_i : result_q;
                state_d  = cnt_q == RD_LAST ? DONE : RD_WAIT;
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default:   state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            base_q   <= '0;
            len_q    <= '0;
            idx_q    <= '0;
            result_q <= '0;
            data_q   <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
`ifdef FEEDER_IRQ_EN
            irq_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
`ifdef FEEDER_IRQ_EN
            irq_q    <= irq_d;
`endif
        end
    end
    assign mem_read_o      = state_q == FETCH;
    assign mem_address_o   = mem_read_o ? base_q + (idx_q << 2) : '0;
    assign acc_write_o     = state_q == CLEAR || state_q == PUSH;
    assign acc_read_o      = state_q == RD_REQ;
    assign acc_address_o   = state_q == CLEAR || acc_read_o;
    assign acc_writedata_o = state_q == PUSH ? data_q : '0;
    assign csr_readdata_o  = !csr_read_i ? '0 :
                             csr_address_i == 2'd0 ? base_q :
                             csr_address_i == 2'd1 ? len_q :
                             csr_address_i == 2'd2 ? status : result_q;
endmodule

// File: doc/vector_feeder.md
VECTOR_FEEDER -- requirements
Module: vector_feeder

Interface
REQ-001 Parameter ACC_DRAIN, default 7: idle cycles after the last accelerator data write before the result read is issued.
REQ-002 Parameter ACC_RD_LAT, default 6: cycles from the accelerator read strobe to valid acc_readdata.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 csr_address  in  2  control slave word address (0 base, 1 length, 2 ctrl/status, 3 result).
REQ-006 csr_write / csr_read  in  1 each  control slave strobes; csr_writedata in 32; csr_readdata out 32, valid the same cycle as csr_read (combinational).
REQ-007 mem_address  out  32  byte address to the memory slave; mem_read out 1; mem_waitrequest in 1; mem_readdata in 32; mem_readdatavalid in 1.
REQ-008 acc_address  out  1  accelerator word address; acc_write, acc_read out 1; acc_writedata out 32; acc_readdata in 32.
REQ-009 irq  out  1  present only when FEEDER_IRQ_EN is defined.

Function
REQ-010 CSR 0 (base) and CSR 1 (length, words) shall be read/write 32-bit registers; writes to them while busy shall be ignored.
REQ-011 CSR 2 read shall return {30'b0, done, busy}; writing bit0=1 while idle shall start a run, clear done, and set busy the next cycle; a start while busy shall be ignored.
REQ-012 CSR 3 shall be read-only and return the last captured result; writes shall be ignored.
REQ-013 FSM states: IDLE, CLEAR, FETCH, WAIT_DATA, PUSH, DRAIN, RD_REQ, RD_WAIT, DONE.
REQ-014 IDLE->CLEAR on start; CLEAR shall drive acc_write=1, acc_address=1, acc_writedata=0 for exactly one cycle.
REQ-015 CLEAR->FETCH if length!=0, else ->DONE with result register set to 0 and no memory or accelerator reads.
REQ-016 FETCH shall hold mem_read=1 with mem_address=base+4*index until a cycle with mem_waitrequest=0, then ->WAIT_DATA.
REQ-017 WAIT_DATA shall latch mem_readdata on mem_readdatavalid and ->PUSH; PUSH shall drive acc_write=1, acc_address=0, acc_writedata=latched word for one cycle.
REQ-018 After PUSH, index shall increment; ->FETCH if index<length, else ->DRAIN.
REQ-019 DRAIN shall wait exactly ACC_DRAIN cycles, then ->RD_REQ; RD_REQ shall drive acc_read=1, acc_address=1 for one cycle, then ->RD_WAIT.
REQ-020 RD_WAIT shall capture acc_readdata into the result register exactly ACC_RD_LAT cycles after the RD_REQ cycle, then ->DONE.
REQ-021 DONE shall set done=1, clear busy, ->IDLE next cycle; done shall stay set until the next start.
REQ-022 mem_address shall wrap modulo 2^32; index and length comparisons shall be unsigned 32-bit.
REQ-023 All strobes (mem_read, acc_write, acc_read) shall be 0 outside their named states; acc_writedata/mem_address shall be 0 when their strobe is 0.
REQ-024 A CSR read and CSR write in the same cycle: read returns pre-write value.

Reset
REQ-025 Reset shall force IDLE, busy=0, done=0, index=0, base/length/result=0, all strobes 0, csr_readdata=0, irq=0, within the asserting edge (asynchronous).
REQ-026 Reset mid-run shall abandon the run without further memory or accelerator transactions; an outstanding mem_readdatavalid after reset deassertion shall be ignored.

Configuration
REQ-027 With FEEDER_IRQ_EN defined: irq shall assert the cycle after DONE and stay high until CSR 2 is written with bit1=1 (clears irq and done) or reset; CSR 2 bit2 shall read 1 while irq is high.
REQ-028 Without FEEDER_IRQ_EN: no irq port, CSR 2 bits 31:2 read 0, bit1 write ignored.

Verification
REQ-029 length=3, base=0x100, memory {0x3F800000,0x40000000,0x40400000}, 0-wait memory -> three acc writes addr0 in order, one addr1 clear first, result=acc_readdata sampled 6 cycles after RD_REQ, done=1.
REQ-030 length=0, start -> one CLEAR write, no mem_read, no acc_read, result=0, done=1 within 3 cycles.
REQ-031 mem_waitrequest held 5 cycles on second fetch -> mem_address stable at base+4 throughout, no extra acc writes.
REQ-032 start written twice during run -> second ignored, exactly length acc data writes.
REQ-033 reset asserted in DRAIN -> all strobes 0 immediately, busy=0, result=0, no acc_read afterward.
REQ-034 FEEDER_IRQ_EN defined, run length=1 -> irq high after DONE, stays high, drops the cycle after CSR 2 write of 0x2.
